// File: rtl/toeplitz_pkg.sv
// Shared definitions for the Toeplitz-hash randomness extractor.
//   N_DEFAULT / L_DEFAULT : default raw bits per block / extracted bits per block
//   seed_width(n, l)      : width of the seed that defines an L x N Toeplitz matrix
//   column(seed, n, l, j) : column j of the matrix, i.e. seed[n-1-j +: l]
package toeplitz_pkg;

    localparam int unsigned N_DEFAULT  = 16;
    localparam int unsigned L_DEFAULT  = 8;
    localparam int unsigned SEED_MAX_W = 64;
    localparam int unsigned COL_MAX_W  = 32;

    function automatic int unsigned seed_width(input int unsigned n, input int unsigned l);
        return n + l - 1;
    endfunction

    // Column j of the Toeplitz matrix; seeds and columns are carried zero-extended.
    function automatic logic [COL_MAX_W-1:0] column(input logic [SEED_MAX_W-1:0] seed,
                                                    input int unsigned n,
                                                    input int unsigned l,
                                                    input int unsigned j);
        logic [SEED_MAX_W-1:0] shifted;
        logic [SEED_MAX_W-1:0] mask;
        shifted = seed >> (n - 1 - j);
        mask    = (l >= SEED_MAX_W) ? '1 : ((SEED_MAX_W'(1) << l) - SEED_MAX_W'(1));
        return COL_MAX_W'(shifted & mask);
    endfunction

endpackage

// File: rtl/toeplitz_column_mux.sv
// Selects one Toeplitz matrix column out of the seed register.
//   seed_i  : current seed (N+L-1 bits)
//   sel_i   : column index (count of bits already accepted in the block)
//   col_c_o : combinational column seed_i[N-1-sel_i +: L]
module toeplitz_column_mux #(
    parameter int unsigned N   = 16,
    parameter int unsigned L   = 8,
    parameter int unsigned NBW = $clog2(N)
) (
    input  logic [N+L-2:0] seed_i,
    input  logic [NBW-1:0] sel_i,
    output logic [L-1:0]   col_c_o
);

    // Indices beyond N-1 cannot occur; they fall through to zero.
    always_comb begin
        col_c_o = '0;
        for (int unsigned j = 0; j < N; j++) begin
            if (sel_i == NBW'(j)) begin
                col_c_o = seed_i[N-1-j +: L];
            end
        end
    end

endmodule

// File: rtl/toeplitz_extractor.sv
// Bit-serial Toeplitz-hash extractor: each block of N raw bits is compressed
// into an L-bit word q = T*x over GF(2), with T defined by a loadable seed.
//   clk, reset : clock, asynchronous active-high reset
//   rbit       : raw random bit, valid when rbiten is high
//   seed       : new seed, loaded when seedload is high (aborts the block)
//   q          : extracted word, updated together with the qstrobe pulse
//   qstrobe    : one-cycle pulse marking a new q
//   nbits      : raw bits accepted so far in the current block
module toeplitz_extractor
    import toeplitz_pkg::*;
#(
    parameter int unsigned N = N_DEFAULT,
    parameter int unsigned L = L_DEFAULT,
    parameter logic [seed_width(N, L)-1:0] SEED_INIT = '0
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        rbit,
    input  logic                        rbiten,
    input  logic [seed_width(N, L)-1:0] seed,
    input  logic                        seedload,
    output logic [L-1:0]                q,
    output logic                        qstrobe,
    output logic [$clog2(N)-1:0]        nbits
);

    localparam int unsigned SW  = seed_width(N, L);
    localparam int unsigned NBW = $clog2(N);

    if (N < L || N < 2) begin : g_bad_params
        $error("toeplitz_extractor: parameters need N >= L and N >= 2");
    end

    logic [SW-1:0]  seed_q,    seed_d;
    logic [L-1:0]   acc_q,     acc_d;
    logic [L-1:0]   q_q,       q_d;
    logic           qstrobe_q, qstrobe_d;
    logic [NBW-1:0] nbits_q,   nbits_d;
    logic [L-1:0]   col_c;
    logic [L-1:0]   acc_next_c;

    toeplitz_column_mux #(
        .N   (N),
        .L   (L),
        .NBW (NBW)
    ) u_column_mux (
        .seed_i  (seed_q),
        .sel_i   (nbits_q),
        .col_c_o (col_c)
    );

    // Accumulator with the current bit's column folded in.
    assign acc_next_c = acc_q ^ (rbit ? col_c : '0);

    // Next-state: seedload aborts the block and wins over a coincident raw bit.
    always_comb begin
        seed_d    = seed_q;
        acc_d     = acc_q;
        q_d       = q_q;
        qstrobe_d = 1'b0;
        nbits_d   = nbits_q;
        if (seedload) begin
            seed_d  = seed;
            acc_d   = '0;
            nbits_d = '0;
        end else if (rbiten) begin
            if (nbits_q == NBW'(N - 1)) begin
                q_d       = acc_next_c;
                qstrobe_d = 1'b1;
                acc_d     = '0;
                nbits_d   = '0;
            end else begin
                acc_d   = acc_next_c;
                nbits_d = nbits_q + NBW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            seed_q    <= SEED_INIT;
            acc_q     <= '0;
            q_q       <= '0;
            qstrobe_q <= 1'b0;
            nbits_q   <= '0;
        end else begin
            seed_q    <= seed_d;
            acc_q     <= acc_d;
            q_q       <= q_d;
            qstrobe_q <= qstrobe_d;
            nbits_q   <= nbits_d;
        end
    end

    assign q       = q_q;
    assign qstrobe = qstrobe_q;
    assign nbits   = nbits_q;

endmodule

// File: tb/tb_toeplitz_extractor.sv
// Self-checking bench for toeplitz_extractor: a small N=4/L=2 instance for the
// directed cases and random blocks, and a default N=16/L=8 instance for long
// back-to-back random runs, both checked against a GF(2) matrix model.
module tb_toeplitz_extractor;
    import toeplitz_pkg::*;

    localparam int unsigned AN = 4;
    localparam int unsigned AL = 2;
    localparam int unsigned AS = AN + AL - 1;
    localparam int unsigned BN = 16;
    localparam int unsigned BL = 8;
    localparam int unsigned BS = BN + BL - 1;

    logic clk = 1'b0;
    logic rst;

    logic          a_rbit, a_rbiten, a_seedload;
    logic [AS-1:0] a_seed;
    logic [AL-1:0] a_q;
    logic          a_qstrobe;
    logic [1:0]    a_nbits;

    logic          b_rbit, b_rbiten, b_seedload;
    logic [BS-1:0] b_seed;
    logic [BL-1:0] b_q;
    logic          b_qstrobe;
    logic [3:0]    b_nbits;

    int n_checks = 0;
    int n_errors = 0;

    toeplitz_extractor #(.N(AN), .L(AL)) dut_a (
        .clk(clk), .reset(rst), .rbit(a_rbit), .rbiten(a_rbiten),
        .seed(a_seed), .seedload(a_seedload),
        .q(a_q), .qstrobe(a_qstrobe), .nbits(a_nbits)
    );

    toeplitz_extractor #(.N(BN), .L(BL)) dut_b (
        .clk(clk), .reset(rst), .rbit(b_rbit), .rbiten(b_rbiten),
        .seed(b_seed), .seedload(b_seedload),
        .q(b_q), .qstrobe(b_qstrobe), .nbits(b_nbits)
    );

    initial forever #5 clk = ~clk;

    // Reference: q[i] = XOR over j of T[i][j]&x[j], T[i][j] = seed[i-j+n-1].
    function automatic logic [63:0] tmodel(input logic [63:0] sd, input int n, input int l,
                                           input logic [63:0] x);
        logic [63:0] r;
        r = '0;
        for (int i = 0; i < l; i++)
            for (int j = 0; j < n; j++)
                if (x[j]) r[i] = r[i] ^ sd[i - j + n - 1];
        return r;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic a_drive(input logic en, input logic b, input logic sl, input logic [AS-1:0] sd);
        a_rbiten = en; a_rbit = b; a_seedload = sl; a_seed = sd;
        @(posedge clk); #1;
    endtask

    task automatic a_bit(input logic b);
        a_drive(1'b1, b, 1'b0, a_seed);
    endtask

    task automatic a_idle();
        a_drive(1'b0, 1'b0, 1'b0, a_seed);
    endtask

    task automatic b_drive(input logic en, input logic b, input logic sl, input logic [BS-1:0] sd);
        b_rbiten = en; b_rbit = b; b_seedload = sl; b_seed = sd;
        @(posedge clk); #1;
    endtask

    initial begin
        logic [AS-1:0] a_cur;
        logic [AL-1:0] exp_q;
        logic [AN-1:0] x;
        logic [11:0]   stream;
        logic [5:0]    words;
        logic [AL-1:0] w;
        logic [BS-1:0] b_cur;
        logic [BN-1:0] bx;
        logic [BL-1:0] b_exp;
        int gaps;

        rst = 1'b1;
        a_rbit = 0; a_rbiten = 0; a_seedload = 0; a_seed = '0;
        b_rbit = 0; b_rbiten = 0; b_seedload = 0; b_seed = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_q", 64'(a_q), 64'(0));
        chk("reset_qstrobe", 64'(a_qstrobe), 64'(0));
        chk("reset_nbits", 64'(a_nbits), 64'(0));
        chk("reset_b_q", 64'(b_q), 64'(0));
        rst = 1'b0;
        a_idle();

        a_cur = 5'b10110;
        a_drive(1'b0, 1'b0, 1'b1, a_cur);
        chk("seedload_nbits", 64'(a_nbits), 64'(0));
        exp_q = '0;

        // Case 1: x = 1,0,1,1 back to back.
        x = 4'b1101;
        for (int i = 0; i < AN; i++) begin
            a_bit(x[i]);
            if (i < AN - 1) begin
                chk($sformatf("t1_strobe_%0d", i), 64'(a_qstrobe), 64'(0));
                chk($sformatf("t1_nbits_%0d", i), 64'(a_nbits), 64'(i + 1));
            end
        end
        exp_q = AL'(tmodel(64'(a_cur), AN, AL, 64'(x)));
        chk("t1_strobe", 64'(a_qstrobe), 64'(1));
        chk("t1_q_model", 64'(a_q), 64'(exp_q));
        chk("t1_q_const", 64'(a_q), 64'(2'b11));
        chk("t1_nbits", 64'(a_nbits), 64'(0));
        a_idle();
        chk("t1_strobe_low", 64'(a_qstrobe), 64'(0));
        chk("t1_q_hold", 64'(a_q), 64'(2'b11));

        // Case 2: 1,1, three idle cycles, 1,1.
        a_bit(1'b1); a_bit(1'b1);
        for (int i = 0; i < 3; i++) begin
            a_idle();
            chk($sformatf("t2_gap_nbits_%0d", i), 64'(a_nbits), 64'(2));
            chk($sformatf("t2_gap_strobe_%0d", i), 64'(a_qstrobe), 64'(0));
        end
        a_bit(1'b1);
        chk("t2_strobe_3rd", 64'(a_qstrobe), 64'(0));
        a_bit(1'b1);
        chk("t2_strobe", 64'(a_qstrobe), 64'(1));
        chk("t2_q", 64'(a_q), 64'(2'b10));
        exp_q = 2'b10;

        // Case 3: blocks 0000, 1011, 1111 back to back (x[0] first in each).
        stream = 12'b1111_1101_0000;
        words  = 6'b10_11_00;
        for (int k = 0; k < 12; k++) begin
            a_bit(stream[k]);
            if (k % 4 == 3) begin
                w = words[(k / 4) * 2 +: 2];
                chk($sformatf("t3_strobe_%0d", k), 64'(a_qstrobe), 64'(1));
                chk($sformatf("t3_q_%0d", k), 64'(a_q), 64'(w));
                exp_q = w;
            end else begin
                chk($sformatf("t3_strobe_%0d", k), 64'(a_qstrobe), 64'(0));
                chk($sformatf("t3_qhold_%0d", k), 64'(a_q), 64'(exp_q));
            end
        end

        // Case 4: seedload aborts a block and swallows a coincident bit.
        a_bit(1'b1); a_bit(1'b0);
        a_cur = 5'b11111;
        a_drive(1'b1, 1'b1, 1'b1, a_cur);
        chk("t4_nbits", 64'(a_nbits), 64'(0));
        chk("t4_strobe", 64'(a_qstrobe), 64'(0));
        chk("t4_q_hold", 64'(a_q), 64'(exp_q));
        a_bit(1'b1); a_bit(1'b1); a_bit(1'b1); a_bit(1'b0);
        chk("t4_strobe2", 64'(a_qstrobe), 64'(1));
        chk("t4_q", 64'(a_q), 64'(2'b11));
        exp_q = 2'b11;

        // Seedload coinciding with the N-th bit: no strobe.
        a_bit(1'b1); a_bit(1'b1); a_bit(1'b1);
        a_cur = 5'b10110;
        a_drive(1'b1, 1'b1, 1'b1, a_cur);
        chk("t4b_strobe", 64'(a_qstrobe), 64'(0));
        chk("t4b_nbits", 64'(a_nbits), 64'(0));
        chk("t4b_q_hold", 64'(a_q), 64'(exp_q));
        a_idle();
        chk("t4b_strobe_after", 64'(a_qstrobe), 64'(0));

        // Case 5: asynchronous reset mid-cycle after 3 bits.
        a_bit(1'b1); a_bit(1'b1); a_bit(1'b1);
        #2 rst = 1'b1;
        #1;
        chk("t5_q", 64'(a_q), 64'(0));
        chk("t5_strobe", 64'(a_qstrobe), 64'(0));
        chk("t5_nbits", 64'(a_nbits), 64'(0));
        @(posedge clk); #1;
        rst = 1'b0;
        a_cur = '0;
        exp_q = '0;
        for (int i = 0; i < 3; i++) begin
            a_idle();
            chk($sformatf("t5_no_strobe_%0d", i), 64'(a_qstrobe), 64'(0));
        end
        for (int i = 0; i < AN; i++) a_bit(1'b1);
        chk("t5_seed_init_strobe", 64'(a_qstrobe), 64'(1));
        chk("t5_seed_init_q", 64'(a_q), 64'(0));

        // Random blocks with random gaps and occasional reseeding.
        for (int blk = 0; blk < 25; blk++) begin
            if ($urandom_range(3) == 0) begin
                a_cur = AS'($urandom);
                a_drive(1'b0, 1'b0, 1'b1, a_cur);
                chk($sformatf("rnd_reseed_nbits_%0d", blk), 64'(a_nbits), 64'(0));
            end
            x = AN'($urandom);
            for (int i = 0; i < AN; i++) begin
                gaps = int'($urandom_range(2));
                repeat (gaps) begin
                    a_idle();
                    chk($sformatf("rnd_gap_strobe_%0d", blk), 64'(a_qstrobe), 64'(0));
                    chk($sformatf("rnd_gap_nbits_%0d", blk), 64'(a_nbits), 64'(i));
                end
                a_bit(x[i]);
                if (i < AN - 1) begin
                    chk($sformatf("rnd_strobe_%0d_%0d", blk, i), 64'(a_qstrobe), 64'(0));
                    chk($sformatf("rnd_qhold_%0d_%0d", blk, i), 64'(a_q), 64'(exp_q));
                end else begin
                    exp_q = AL'(tmodel(64'(a_cur), AN, AL, 64'(x)));
                    chk($sformatf("rnd_strobe_%0d", blk), 64'(a_qstrobe), 64'(1));
                    chk($sformatf("rnd_q_%0d", blk), 64'(a_q), 64'(exp_q));
                    chk($sformatf("rnd_nbits_%0d", blk), 64'(a_nbits), 64'(0));
                end
            end
        end
        a_idle();

        // Default-size instance: 20 back-to-back random blocks.
        b_cur = BS'({$urandom, $urandom});
        b_drive(1'b0, 1'b0, 1'b1, b_cur);
        b_exp = '0;
        for (int blk = 0; blk < 20; blk++) begin
            bx = BN'($urandom);
            for (int i = 0; i < BN; i++) begin
                b_drive(1'b1, bx[i], 1'b0, b_cur);
                if (i < BN - 1) begin
                    chk($sformatf("big_strobe_%0d_%0d", blk, i), 64'(b_qstrobe), 64'(0));
                    chk($sformatf("big_qhold_%0d_%0d", blk, i), 64'(b_q), 64'(b_exp));
                end else begin
                    b_exp = BL'(tmodel(64'(b_cur), BN, BL, 64'(bx)));
                    chk($sformatf("big_strobe_%0d", blk), 64'(b_qstrobe), 64'(1));
                    chk($sformatf("big_q_%0d", blk), 64'(b_q), 64'(b_exp));
                end
            end
        end
        b_drive(1'b0, 1'b0, 1'b0, b_cur);
        chk("big_strobe_end", 64'(b_qstrobe), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
